// File: rtl/sentinel_seq_lock.sv
// Sequence lock: KEY_LEN-symbol key entry with fail counting, timed lockout and 7-seg/status display.
// Optional SENTINEL_SHADOW_EN adds an inverted shadow of state/idx; any disagreement latches PANIC.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   LOCKED   | accepting key symbols, idx = next symbol to compare
//   UNLOCKED | full key matched, waits for relock
//   LOCKOUT  | MAX_FAIL wrong symbols seen, timer counting down
//   PANIC    | shadow disagreement (shadow build only), left by rst only
module sentinel_seq_lock #(
  parameter int                          DATA_W         = 8,
  parameter int                          KEY_LEN        = 4,
  parameter logic [KEY_LEN*DATA_W-1:0]   KEY            = 32'hB61FA05C,
  parameter int                          MAX_FAIL       = 3,
  parameter int                          LOCKOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] key_in,
  input  logic              key_valid,
  input  logic              relock,
  output logic              unlocked,
  output logic              lockout,
  output logic              panic,
  output logic [3:0]        fail_cnt,
  output logic [7:0]        seg_out,
  output logic [7:0]        status
);

  localparam int                IDX_W      = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int                TIMER_W    = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(KEY_LEN - 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LOCKOUT_CYCLES);
  localparam logic [3:0]        FAIL_LIMIT = 4'(MAX_FAIL);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2,
    PANIC    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [3:0]           fail_q, fail_d, fail_inc;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [7:0]           seg_q, seg_d;
  logic [KEY_LEN*DATA_W-1:0] key_shift;
  logic [DATA_W-1:0]    key_sym;

  function automatic logic [7:0] seg_of(input state_t s);
    case (s)
      LOCKED:   seg_of = 8'hC7;
      UNLOCKED: seg_of = 8'hC1;
      LOCKOUT:  seg_of = 8'hBF;
      default:  seg_of = 8'h86;
    endcase
  endfunction

  // Symbol 0 sits in the most significant DATA_W bits of KEY.
  always_comb begin
    key_shift = KEY >> (DATA_W * (KEY_LEN - 1 - int'(idx_q)));
    key_sym   = key_shift[DATA_W-1:0];
  end

`ifdef SENTINEL_SHADOW_EN
  logic [1:0]       state_sh_q;
  logic [IDX_W-1:0] idx_sh_q;
  logic             shadow_err;

  assign shadow_err = (state_sh_q != ~state_q) || (idx_sh_q != ~idx_q);
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    timer_d  = timer_q;
    fail_inc = fail_q + 4'd1;

    if (ena) begin
      case (state_q)
        LOCKED: begin
          if (relock) begin
            idx_d = '0;
          end else if (key_valid) begin
            if (key_in == key_sym) begin
              if (idx_q == IDX_LAST) begin
                state_d = UNLOCKED;
                idx_d   = '0;
                fail_d  = 4'd0;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end else begin
              idx_d  = '0;
              fail_d = fail_inc;
              if (fail_inc == FAIL_LIMIT) begin
                state_d = LOCKOUT;
                timer_d = TIMER_LOAD;
              end
            end
          end
        end
        UNLOCKED: begin
          if (relock) begin
            state_d = LOCKED;
            idx_d   = '0;
          end
        end
        LOCKOUT: begin
          // Leaving on the count-of-one cycle keeps lockout high for exactly LOCKOUT_CYCLES cycles.
          if (timer_q <= TIMER_W'(1)) begin
            state_d = LOCKED;
            timer_d = '0;
            fail_d  = 4'd0;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: ;
      endcase
    end

`ifdef SENTINEL_SHADOW_EN
    if (shadow_err) begin
      state_d = PANIC;
      timer_d = '0;
    end
`endif

    seg_d = ena ? seg_of(state_d) : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOCKED;
      idx_q   <= '0;
      fail_q  <= 4'd0;
      timer_q <= '0;
      seg_q   <= 8'hC7;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      seg_q   <= seg_d;
    end
  end

`ifdef SENTINEL_SHADOW_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_sh_q <= ~LOCKED;
      idx_sh_q   <= '1;
    end else begin
      state_sh_q <= ~state_d;
      idx_sh_q   <= ~idx_d;
    end
  end

  assign panic = (state_q == PANIC);
`else
  assign panic = 1'b0;
`endif

  assign unlocked = (state_q == UNLOCKED);
  assign lockout  = (state_q == LOCKOUT);
  assign fail_cnt = fail_q;
  assign seg_out  = seg_q;

  always_comb begin
    status = 8'h00;
    if (ena) begin
      case (state_q)
        LOCKED:   status = {4'b0000, fail_q};
        UNLOCKED: status = 8'hFF;
        LOCKOUT:  status = 8'hAA;
        default:  status = 8'h55;
      endcase
    end
  end

endmodule
